// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the unified I/D SRAM arbiter.
// Contents: response owner enum, word size, byte-to-word address slice
// position, streak counter width.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam int unsigned WORD_BYTES = 4;
  // Lowest byte-address bit that forms part of the SRAM word address.
  localparam int unsigned WORD_LSB   = $clog2(WORD_BYTES);
  localparam int unsigned STREAK_W   = 4;

endpackage

// File: rtl/riscv_mem_arb_streak.sv
// Fetch starvation guard: counts consecutive data grants taken while a fetch
// is waiting and raises force_if once the count reaches MAX_D_STREAK.
// Ports: clk, rst (sync, active-high), if_req, d_gnt, if_gnt in; force_if out.
module riscv_mem_arb_streak
  import riscv_mem_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic d_gnt,
  input  logic if_gnt,
  output logic force_if
);

  logic [STREAK_W-1:0] streak_q, streak_d;

  // Clear whenever fetch is served or not waiting; saturate at the limit.
  always_comb begin
    streak_d = streak_q;
    if (if_gnt || !if_req) begin
      streak_d = '0;
    end else if (d_gnt && (streak_q < STREAK_W'(MAX_D_STREAK))) begin
      streak_d = streak_q + STREAK_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) streak_q <= '0;
    else     streak_q <= streak_d;
  end

  assign force_if = (streak_q == STREAK_W'(MAX_D_STREAK));

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one single-port synchronous SRAM (1-cycle read latency) between the
// fetch port and the load/store port. Data wins by default; fetch is forced
// through after MAX_D_STREAK consecutive data grants while it waits.
// Ports: CLK, RST (sync, active-high); IF_* fetch port; D_* load/store port;
// MEM_* SRAM interface (CSN/WEN active low). Grants and SRAM drive are
// combinational from the requests; read data is returned the cycle after
// the grant to the requester that issued it.
// Optional: define RISCV_MEM_ARB_PERF_EN to add PERF_CONFLICTS and
// PERF_IF_STALLS saturating event counters.
module riscv_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned AWIDTH       = 12,
  parameter int unsigned DWIDTH       = 32,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IF_REQ,
  input  logic [AWIDTH+1:0] IF_ADDR,
  output logic              IF_GNT,
  output logic              IF_RVALID,
  output logic [DWIDTH-1:0] IF_RDATA,
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic [3:0]        D_BE,
  input  logic [AWIDTH+1:0] D_ADDR,
  input  logic [DWIDTH-1:0] D_WDATA,
  output logic              D_GNT,
  output logic              D_RVALID,
  output logic [DWIDTH-1:0] D_RDATA,
  output logic              MEM_CSN,
  output logic              MEM_WEN,
  output logic [3:0]        MEM_BE,
  output logic [AWIDTH-1:0] MEM_ADDR,
  output logic [DWIDTH-1:0] MEM_DI,
  input  logic [DWIDTH-1:0] MEM_DOUT
`ifdef RISCV_MEM_ARB_PERF_EN
  ,
  output logic [31:0]       PERF_CONFLICTS,
  output logic [31:0]       PERF_IF_STALLS
`endif
);

  logic        force_if;
  logic        if_gnt_c, d_gnt_c;
  logic        if_rvalid_c, d_rvalid_c;
  owner_e      owner_q, owner_d;

  logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [DWIDTH-1:0] mem_di_q, mem_di_d;
  logic [DWIDTH-1:0] if_rdata_q, d_rdata_q;

  // Byte-offset bits are dropped by the word slice.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{IF_ADDR[WORD_LSB-1:0], D_ADDR[WORD_LSB-1:0]};

  riscv_mem_arb_streak #(
    .MAX_D_STREAK (MAX_D_STREAK)
  ) u_streak (
    .clk      (CLK),
    .rst      (RST),
    .if_req   (IF_REQ),
    .d_gnt    (d_gnt_c),
    .if_gnt   (if_gnt_c),
    .force_if (force_if)
  );

  // Grant mux: data priority unless the streak guard forces fetch.
  always_comb begin
    if_gnt_c = 1'b0;
    d_gnt_c  = 1'b0;
    if (!RST) begin
      if (IF_REQ && (!D_REQ || force_if)) if_gnt_c = 1'b1;
      else if (D_REQ)                     d_gnt_c  = 1'b1;
    end
  end

  assign IF_GNT = if_gnt_c;
  assign D_GNT  = d_gnt_c;

  // SRAM drive; address/byte-enable/write-data hold while idle.
  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_be_d   = mem_be_q;
    mem_di_d   = mem_di_q;
    owner_d    = OWN_NONE;
    if (if_gnt_c) begin
      mem_addr_d = IF_ADDR[AWIDTH+WORD_LSB-1:WORD_LSB];
      mem_be_d   = 4'b0000;
      owner_d    = OWN_IF;
    end else if (d_gnt_c) begin
      mem_addr_d = D_ADDR[AWIDTH+WORD_LSB-1:WORD_LSB];
      if (D_WE) begin
        mem_be_d = D_BE;
        mem_di_d = D_WDATA;
      end else begin
        mem_be_d = 4'b0000;
        owner_d  = OWN_D;
      end
    end
  end

  assign MEM_CSN  = ~(if_gnt_c | d_gnt_c);
  assign MEM_WEN  = ~(d_gnt_c & D_WE);
  assign MEM_ADDR = mem_addr_d;
  assign MEM_BE   = mem_be_d;
  assign MEM_DI   = mem_di_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      mem_addr_q <= '0;
      mem_be_q   <= '0;
      mem_di_q   <= '0;
      owner_q    <= OWN_NONE;
    end else begin
      mem_addr_q <= mem_addr_d;
      mem_be_q   <= mem_be_d;
      mem_di_q   <= mem_di_d;
      owner_q    <= owner_d;
    end
  end

  // Response routing; a reset in the response cycle drops the read.
  assign if_rvalid_c = !RST && (owner_q == OWN_IF);
  assign d_rvalid_c  = !RST && (owner_q == OWN_D);

  assign IF_RVALID = if_rvalid_c;
  assign D_RVALID  = d_rvalid_c;
  assign IF_RDATA  = if_rvalid_c ? MEM_DOUT : if_rdata_q;
  assign D_RDATA   = d_rvalid_c  ? MEM_DOUT : d_rdata_q;

  // Keep the last delivered word visible on each read-data port.
  always_ff @(posedge CLK) begin
    if (RST) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (if_rvalid_c) if_rdata_q <= MEM_DOUT;
      if (d_rvalid_c)  d_rdata_q  <= MEM_DOUT;
    end
  end

`ifdef RISCV_MEM_ARB_PERF_EN
  logic [31:0] perf_conf_q, perf_stall_q;

  // Saturating event counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_conf_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (IF_REQ && D_REQ && (perf_conf_q != 32'hFFFF_FFFF))
        perf_conf_q <= perf_conf_q + 32'd1;
      if (IF_REQ && !if_gnt_c && (perf_stall_q != 32'hFFFF_FFFF))
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign PERF_CONFLICTS = perf_conf_q;
  assign PERF_IF_STALLS = perf_stall_q;
`endif

endmodule
